mod_counter_n: RTL and testbench

- Parametrised successor to the team's 3-bit free-running flip-flop counter.
- Generalised to WIDTH bits and an arbitrary modulus.
- Adds runtime-selectable modes (up, down, ping-pong, hold), synchronous load, count enable, a registered terminal-count pulse and a Gray-coded output.
- Sits in the digital lab designs as the standard counter/sequencer feeding displays, dividers and FSM timers.

---
 rtl/ctr_pkg.sv | 14 +
 rtl/mod_counter_n_bin2gray.sv | 12 +
 rtl/mod_counter_n.sv | 123 ++++++++++++
 tb/tb_mod_counter_n.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ctr_pkg.sv
// rtl/ctr_pkg.sv - shared mode and direction encodings for mod_counter_n
package ctr_pkg;

   // Counting mode, selected at runtime by the MODE input
   localparam logic [1:0] MODE_UP       = 2'b00;
   localparam logic [1:0] MODE_DOWN     = 2'b01;
   localparam logic [1:0] MODE_PINGPONG = 2'b10;
   localparam logic [1:0] MODE_HOLD     = 2'b11;

   // Direction flag as presented on DIR
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/mod_counter_n_bin2gray.sv
// rtl/mod_counter_n_bin2gray.sv - combinational binary to Gray converter
module bin2gray #(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] bin_i,
   output logic [WIDTH-1:0] gray_o
);

   // Adjacent bits XORed; the MSB passes through unchanged
   assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/mod_counter_n.sv
// rtl/mod_counter_n.sv - modulo-N up/down/ping-pong counter with load and TC
module mod_counter_n #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic [1:0]       MODE,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Q_GRAY,
   output logic             DIR,
   output logic             TC
);

   import ctr_pkg::*;

   generate
      if ((WIDTH < 1) || (WIDTH > 16) || (MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_param
         $error("mod_counter_n: MODULUS must lie in 2..2**WIDTH and WIDTH in 1..16");
      end
   endgenerate

   // Top count, the value after a reversal at the top, and the unit step
   localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] Q_MAX_M1 = WIDTH'(MODULUS - 2);
   localparam logic [WIDTH-1:0] Q_ONE    = WIDTH'(1);

   logic [WIDTH-1:0] q_q, q_d;
   logic             dir_q, dir_d;
   logic             tc_q, tc_d;

   logic d_in_range;
   logic q_at_top;
   logic q_at_zero;

   // Load clamp compares in 32 bits so MODULUS == 2**WIDTH needs no special case
   assign d_in_range = (32'(D) < 32'(MODULUS));
   // Anything at or above the top count is terminal when counting up
   assign q_at_top   = (q_q >= Q_MAX);
   assign q_at_zero  = (q_q == '0);

   // Next-state selection: LOAD beats EN; TC only pulses on wrap or reversal
   always_comb begin
      q_d   = q_q;
      dir_d = dir_q;
      tc_d  = 1'b0;
      if (LOAD) begin
         q_d = d_in_range ? D : Q_MAX;
      end else if (EN) begin
         case (MODE)
            MODE_UP: begin
               dir_d = DIR_UP;
               if (q_at_top) begin
                  q_d  = '0;
                  tc_d = 1'b1;
               end else begin
                  q_d = q_q + Q_ONE;
               end
            end
            MODE_DOWN: begin
               dir_d = DIR_DOWN;
               if (q_at_zero) begin
                  q_d  = Q_MAX;
                  tc_d = 1'b1;
               end else begin
                  q_d = q_q - Q_ONE;
               end
            end
            MODE_PINGPONG: begin
               if (dir_q == DIR_UP) begin
                  if (q_at_top) begin
                     q_d   = Q_MAX_M1;
                     dir_d = DIR_DOWN;
                     tc_d  = 1'b1;
                  end else begin
                     q_d = q_q + Q_ONE;
                  end
               end else begin
                  if (q_at_zero) begin
                     q_d   = Q_ONE;
                     dir_d = DIR_UP;
                     tc_d  = 1'b1;
                  end else begin
                     q_d = q_q - Q_ONE;
                  end
               end
            end
            default: begin
               q_d   = q_q;
               dir_d = dir_q;
            end
         endcase
      end
   end

   // State registers with synchronous reset that overrides load and enable
   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q   <= '0;
         dir_q <= DIR_UP;
         tc_q  <= 1'b0;
      end else begin
         q_q   <= q_d;
         dir_q <= dir_d;
         tc_q  <= tc_d;
      end
   end

   bin2gray #(
      .WIDTH (WIDTH)
   ) u_bin2gray (
      .bin_i  (q_q),
      .gray_o (Q_GRAY)
   );

   assign Q   = q_q;
   assign DIR = dir_q;
   assign TC  = tc_q;

endmodule

// File: tb/tb_mod_counter_n.sv
// tb/tb_mod_counter_n.sv - scoreboard bench for mod_counter_n across four moduli
module tb_mod_counter_n;

   logic       clk;
   logic       rst  [4];
   logic       en   [4];
   logic [1:0] mode [4];
   logic       load [4];
   logic [2:0] d    [4];
   logic [2:0] q    [4];
   logic [2:0] qg   [4];
   logic       dir  [4];
   logic       tc   [4];

   typedef struct {
      int         id;
      logic [2:0] q;
      logic       dir;
      logic       tc;
      string      nm;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_vec = 0;
   int   n_err = 0;

   logic [2:0] gtbl [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

   int pp_q [13] = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2, 3, 4, 3};
   int pp_d [13] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
   int pp_t [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};
   int dn_q [8]  = '{5, 4, 3, 2, 1, 0, 5, 4};
   int dn_t [8]  = '{1, 0, 0, 0, 0, 0, 1, 0};
   int p2_q [5]  = '{1, 0, 1, 0, 1};
   int p2_d [5]  = '{1, 0, 1, 0, 1};
   int p2_t [5]  = '{0, 1, 1, 1, 1};

   mod_counter_n #(.WIDTH(3), .MODULUS(8)) u_m8 (
      .CLK(clk), .RST(rst[0]), .EN(en[0]), .MODE(mode[0]), .LOAD(load[0]), .D(d[0]),
      .Q(q[0]), .Q_GRAY(qg[0]), .DIR(dir[0]), .TC(tc[0]));
   mod_counter_n #(.WIDTH(3), .MODULUS(6)) u_m6 (
      .CLK(clk), .RST(rst[1]), .EN(en[1]), .MODE(mode[1]), .LOAD(load[1]), .D(d[1]),
      .Q(q[1]), .Q_GRAY(qg[1]), .DIR(dir[1]), .TC(tc[1]));
   mod_counter_n #(.WIDTH(3), .MODULUS(5)) u_m5 (
      .CLK(clk), .RST(rst[2]), .EN(en[2]), .MODE(mode[2]), .LOAD(load[2]), .D(d[2]),
      .Q(q[2]), .Q_GRAY(qg[2]), .DIR(dir[2]), .TC(tc[2]));
   mod_counter_n #(.WIDTH(3), .MODULUS(2)) u_m2 (
      .CLK(clk), .RST(rst[3]), .EN(en[3]), .MODE(mode[3]), .LOAD(load[3]), .D(d[3]),
      .Q(q[3]), .Q_GRAY(qg[3]), .DIR(dir[3]), .TC(tc[3]));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Drive one DUT for one edge and queue what it must show afterwards
   task automatic step(input int id, input logic r, input logic l, input logic ev,
                       input logic [1:0] m, input logic [2:0] dv,
                       input int eq, input int ed, input int et, input string nm);
      exp_t x;
      @(negedge clk);
      rst[id]  = r;
      load[id] = l;
      en[id]   = ev;
      mode[id] = m;
      d[id]    = dv;
      x.id  = id;
      x.q   = 3'(eq);
      x.dir = ed[0];
      x.tc  = et[0];
      x.nm  = nm;
      sb.push_back(x);
      @(posedge clk);
   endtask

   // Monitor: after each edge, pop the oldest expectation and check that DUT
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_vec++;
         if (q[e.id] !== e.q) begin
            n_err++;
            $display("FAIL %s.q dut%0d: got %0d required %0d", e.nm, e.id, q[e.id], e.q);
         end
         n_vec++;
         if (dir[e.id] !== e.dir) begin
            n_err++;
            $display("FAIL %s.dir dut%0d: got %0b required %0b", e.nm, e.id, dir[e.id], e.dir);
         end
         n_vec++;
         if (tc[e.id] !== e.tc) begin
            n_err++;
            $display("FAIL %s.tc dut%0d: got %0b required %0b", e.nm, e.id, tc[e.id], e.tc);
         end
         n_vec++;
         if (qg[e.id] !== gtbl[e.q]) begin
            n_err++;
            $display("FAIL %s.gray dut%0d: got %b required %b", e.nm, e.id, qg[e.id], gtbl[e.q]);
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) begin
         rst[i] = 1'b1; en[i] = 1'b0; mode[i] = 2'b00; load[i] = 1'b0; d[i] = 3'd0;
      end

      // MODULUS=8 up counting, wrap, load, enable and hold behaviour
      step(0, 1, 0, 1, 2'b00, 0, 0, 1, 0, "m8_reset");
      step(0, 1, 0, 1, 2'b00, 0, 0, 1, 0, "m8_reset");
      for (int i = 0; i < 25; i++)
         step(0, 0, 0, 1, 2'b00, 0, (i + 1) % 8, 1, ((i + 1) % 8 == 0) ? 1 : 0, "m8_up");
      step(0, 0, 0, 1, 2'b00, 0, 2, 1, 0, "m8_up_to2");
      step(0, 0, 1, 1, 2'b00, 6, 6, 1, 0, "m8_load6");
      step(0, 0, 1, 1, 2'b00, 3, 3, 1, 0, "m8_load3");
      for (int i = 0; i < 3; i++)
         step(0, 0, 0, 0, 2'b00, 0, 3, 1, 0, "m8_en0");
      step(0, 0, 1, 1, 2'b00, 7, 7, 1, 0, "m8_load7");
      step(0, 0, 0, 1, 2'b00, 0, 0, 1, 1, "m8_wrap");
      step(0, 0, 0, 0, 2'b00, 0, 0, 1, 0, "m8_tc_clear_en0");
      step(0, 0, 0, 1, 2'b11, 0, 0, 1, 0, "m8_hold");
      step(0, 0, 0, 1, 2'b11, 0, 0, 1, 0, "m8_hold");
      step(0, 0, 1, 1, 2'b00, 5, 5, 1, 0, "m8_load5");
      step(0, 0, 0, 1, 2'b01, 0, 4, 0, 0, "m8_up2down");
      step(0, 1, 1, 1, 2'b01, 6, 0, 1, 0, "m8_rst_load");
      step(0, 0, 0, 1, 2'b00, 0, 1, 1, 0, "m8_after_rst");

      // MODULUS=6 down counting and load clamp
      step(1, 1, 0, 1, 2'b01, 0, 0, 1, 0, "m6_reset");
      step(1, 1, 0, 1, 2'b01, 0, 0, 1, 0, "m6_reset");
      for (int i = 0; i < 8; i++)
         step(1, 0, 0, 1, 2'b01, 0, dn_q[i], 0, dn_t[i], "m6_down");
      step(1, 0, 1, 1, 2'b01, 7, 5, 0, 0, "m6_clamp7");
      step(1, 0, 1, 1, 2'b01, 6, 5, 0, 0, "m6_clamp6");
      step(1, 0, 1, 1, 2'b01, 4, 4, 0, 0, "m6_load4");
      step(1, 0, 1, 0, 2'b00, 5, 5, 0, 0, "m6_load5");
      step(1, 0, 0, 1, 2'b00, 0, 0, 1, 1, "m6_up_wrap");

      // MODULUS=5 ping-pong, then reset in the middle of a downward run
      step(2, 1, 0, 1, 2'b10, 0, 0, 1, 0, "m5_reset");
      step(2, 1, 0, 1, 2'b10, 0, 0, 1, 0, "m5_reset");
      for (int i = 0; i < 13; i++)
         step(2, 0, 0, 1, 2'b10, 0, pp_q[i], pp_d[i], pp_t[i], "m5_pp");
      step(2, 1, 0, 1, 2'b10, 0, 0, 1, 0, "m5_mid_rst");
      step(2, 0, 0, 1, 2'b10, 0, 1, 1, 0, "m5_resume");
      step(2, 0, 0, 1, 2'b10, 0, 2, 1, 0, "m5_resume");

      // MODULUS=2 ping-pong reverses on every edge once running
      step(3, 1, 0, 1, 2'b10, 0, 0, 1, 0, "m2_reset");
      for (int i = 0; i < 5; i++)
         step(3, 0, 0, 1, 2'b10, 0, p2_q[i], p2_d[i], p2_t[i], "m2_pp");

      repeat (3) @(posedge clk);
      #2;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
